// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
//
// Shared types for the EX-stage forwarding / load-use hazard control.
//
//   fwd_sel_t      2-bit operand-mux select code. 2'b11 is never produced.
//   stage_entry_t  one slot of the shadow pipeline {valid, rd, regwrite,
//                  memread} tracked for the EX, MEM and WB stages.
//   REG_ZERO       index of the hard-wired zero register.
//   is_writer()    true when an entry will really update a register.
// ---------------------------------------------------------------------------
package fwd_pkg;

  // Register index width held in the shadow entries. The top-level
  // REG_ADDR_W parameter is expected to match this value.
  localparam int RD_W = 5;

  localparam logic [RD_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register-file read data
    FWD_WB  = 2'b01,  // MEM/WB result (writeback data)
    FWD_MEM = 2'b10   // EX/MEM result (ALU output)
  } fwd_sel_t;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            regwrite;
    logic            memread;
  } stage_entry_t;

  // An entry only counts as a producer when it is real, writes, and does
  // not target x0 (writes to x0 are discarded, so nothing can depend on them).
  function automatic logic is_writer(input stage_entry_t e);
    return e.valid & e.regwrite & (e.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// ---------------------------------------------------------------------------
// fwd_sel_gen
//
// Combinational priority compare of one source register index against the
// shadow entries of the instructions that will sit ahead of it once it moves
// into EX.
//
// Ports:
//   use_rs     in   source is actually read by the instruction in ID
//   rs         in   source register index
//   ex_entry   in   shadow entry currently in EX  (will be in MEM next cycle)
//   mem_entry  in   shadow entry currently in MEM (will be in WB next cycle)
//   wb_entry   in   shadow entry currently in WB  (retiring this cycle)
//   sel        out  select code the instruction will use once in EX
// ---------------------------------------------------------------------------
module fwd_sel_gen
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = RD_W
) (
  input  logic                  use_rs,
  input  logic [REG_ADDR_W-1:0] rs,
  input  stage_entry_t          ex_entry,
  input  stage_entry_t          mem_entry,
  input  stage_entry_t          wb_entry,
  output fwd_sel_t              sel
);

  logic [RD_W-1:0] rs_w;

  assign rs_w = RD_W'(rs);

  // The youngest producer wins: an EX-stage match means the value will be
  // on the EX/MEM bypass next cycle, a MEM-stage match means it will be on
  // the writeback bus. A match against the retiring WB entry resolves to
  // the register file, because the register file is write-first and already
  // presents the new value on its read port.
  always_comb begin
    sel = FWD_RF;
    if (use_rs && is_writer(ex_entry) && (rs_w == ex_entry.rd)) begin
      sel = FWD_MEM;
    end else if (use_rs && is_writer(mem_entry) && (rs_w == mem_entry.rd)) begin
      sel = FWD_WB;
    end else if (use_rs && is_writer(wb_entry) && (rs_w == wb_entry.rd)) begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Control side of EX-stage operand selection. Tracks a shadow copy of the
// destination / write-enable / load flags for EX, MEM and WB, produces the
// registered operand-mux select codes that arrive together with the
// instruction entering EX, and detects load-use hazards.
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   id_valid      in   ID holds a real instruction
//   id_rs1/rs2    in   source register indices
//   id_use_rs1/2  in   instruction reads the corresponding source
//   id_rd         in   destination register index
//   id_regwrite   in   instruction writes rd
//   id_memread    in   instruction is a load
//   flush         in   redirect resolved in EX, kill the ID instruction
//   ex_fwd_a_sel  out  operand A select for the instruction now in EX
//   ex_fwd_b_sel  out  operand B select for the instruction now in EX
//   stall         out  hold PC and IF/ID this cycle
//   bubble        out  ID/EX loads a NOP this cycle
//   stall_cnt     out  saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [REG_ADDR_W-1:0]  id_rs1,
  input  logic [REG_ADDR_W-1:0]  id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic [REG_ADDR_W-1:0]  id_rd,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   flush,
  output logic [1:0]             ex_fwd_a_sel,
  output logic [1:0]             ex_fwd_b_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  stage_entry_t ex_q, ex_d;
  stage_entry_t mem_q, mem_d;
  stage_entry_t wb_q, wb_d;

  fwd_sel_t sel_a_q, sel_a_d;
  fwd_sel_t sel_b_q, sel_b_d;
  fwd_sel_t gen_a, gen_b;

  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic rs1_hits_ex;
  logic rs2_hits_ex;

  // Per-source select generation against the shadow pipeline.
  fwd_sel_gen #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sel_a (
    .use_rs    (id_use_rs1),
    .rs        (id_rs1),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (gen_a)
  );

  fwd_sel_gen #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_sel_b (
    .use_rs    (id_use_rs2),
    .rs        (id_rs2),
    .ex_entry  (ex_q),
    .mem_entry (mem_q),
    .wb_entry  (wb_q),
    .sel       (gen_b)
  );

  // Load-use detection: a load in EX only has its data at the end of MEM,
  // so a consumer in ID cannot take it from the EX/MEM bypass and must wait
  // one cycle. A flushed ID instruction is dead, so it never stalls.
  always_comb begin
    rs1_hits_ex = id_use_rs1 && (RD_W'(id_rs1) == ex_q.rd);
    rs2_hits_ex = id_use_rs2 && (RD_W'(id_rs2) == ex_q.rd);
    stall  = id_valid && !flush && is_writer(ex_q) && ex_q.memread &&
             (rs1_hits_ex || rs2_hits_ex);
    bubble = stall || flush;
  end

  // Next state of the shadow pipeline and select registers. When a bubble
  // is inserted the EX slot goes empty and the selects fall back to the
  // register file, so the NOP never picks up a bypass value.
  always_comb begin
    wb_d  = mem_q;
    mem_d = ex_q;

    ex_d = '0;
    if (id_valid && !bubble) begin
      ex_d.valid    = 1'b1;
      ex_d.rd       = RD_W'(id_rd);
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
    end

    sel_a_d = FWD_RF;
    sel_b_d = FWD_RF;
    if (!bubble) begin
      sel_a_d = gen_a;
      sel_b_d = gen_b;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // State registers. Reset empties the shadow so nothing can forward from
  // or stall on an instruction that existed before reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      sel_a_q     <= FWD_RF;
      sel_b_q     <= FWD_RF;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_fwd_a_sel = sel_a_q;
  assign ex_fwd_b_sel = sel_b_q;
  assign stall_cnt    = stall_cnt_q;

endmodule
